// File: rtl/serial_subtractor.sv
// serial_subtractor
// -----------------------------------------------------------------------------
// Bit-serial two's-complement subtractor. A single full-subtractor cell and a
// registered borrow compute minuend - subtrahend - borrow_in LSB-first, one bit
// per clock. Operands are taken on a valid/ready handshake and the result is
// offered on a second valid/ready handshake.
//
// Parameters:
//   WIDTH        operand / result width in bits (>= 1)
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   in_valid     operands and borrow_in are valid
//   in_ready     block can accept operands (high only in IDLE)
//   minuend      left operand
//   subtrahend   right operand
//   borrow_in    borrow subtracted at bit 0
//   out_valid    result valid (DONE)
//   out_ready    consumer accepts result
//   difference   result, modulo 2^WIDTH
//   borrow_out   final borrow (1 <=> unsigned minuend < subtrahend + borrow_in)
//   busy         high in SHIFT or DONE
//   overflow     signed overflow flag, only when SERIAL_SUB_OVERFLOW_EN is defined
//
// Build option:
//   SERIAL_SUB_OVERFLOW_EN  adds the overflow port and its flag register.
// -----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] minuend,
    input  logic [WIDTH-1:0] subtrahend,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] difference,
    output logic             borrow_out,
    output logic             busy
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   m_sh;
    logic [WIDTH-1:0]   s_sh;
    logic               brw;
    logic [CNT_W-1:0]   cnt;

`ifdef SERIAL_SUB_OVERFLOW_EN
    logic               m_msb;
    logic               s_msb;
`endif

    // Full-subtractor cell on the current LSBs.
    logic               bit_a;
    logic               bit_b;
    logic               bit_d;
    logic               brw_nxt;
    logic [WIDTH:0]     diff_ext;
    logic [WIDTH-1:0]   diff_nxt;
    logic               last_bit;

    always_comb begin
        bit_a    = m_sh[0];
        bit_b    = s_sh[0];
        bit_d    = bit_a ^ bit_b ^ brw;
        brw_nxt  = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & brw);
        // New bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
        // The extended concat keeps this legal for WIDTH=1.
        diff_ext = {bit_d, difference};
        diff_nxt = diff_ext[WIDTH:1];
        last_bit = (cnt == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            difference <= '0;
            borrow_out <= 1'b0;
            m_sh       <= '0;
            s_sh       <= '0;
            brw        <= 1'b0;
            cnt        <= '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            m_msb      <= 1'b0;
            s_msb      <= 1'b0;
            overflow   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        m_sh     <= minuend;
                        s_sh     <= subtrahend;
                        brw      <= borrow_in;
                        cnt      <= '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
                        m_msb    <= minuend[WIDTH-1];
                        s_msb    <= subtrahend[WIDTH-1];
`endif
                        state    <= SHIFT;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end

                SHIFT: begin
                    m_sh       <= m_sh >> 1;
                    s_sh       <= s_sh >> 1;
                    brw        <= brw_nxt;
                    borrow_out <= brw_nxt;
                    difference <= diff_nxt;
                    cnt        <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
`ifdef SERIAL_SUB_OVERFLOW_EN
                        // bit_d is the final difference MSB on this edge.
                        overflow  <= (m_msb ^ s_msb) & (bit_d ^ m_msb);
`endif
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8). Expected results are
// pushed to a queue when operands are accepted and popped when the DUT hands a
// result over. Inputs change 1ns after the rising edge; outputs are sampled on
// the falling edge.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] minuend;
    logic [W-1:0] subtrahend;
    logic         borrow_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] difference;
    logic         borrow_out;
    logic         busy;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic         overflow;
`endif

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .minuend    (minuend),
        .subtrahend (subtrahend),
        .borrow_in  (borrow_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .difference (difference),
        .borrow_out (borrow_out),
        .busy       (busy)
`ifdef SERIAL_SUB_OVERFLOW_EN
        ,
        .overflow   (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic         b;
        logic         ov;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   errors  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] m, input logic [W-1:0] s, input logic b);
        exp_t     e;
        logic [W:0] r;
        r    = {1'b0, m} - {1'b0, s} - {{W{1'b0}}, b};
        e.d  = r[W-1:0];
        e.b  = r[W];
        e.ov = (m[W-1] != s[W-1]) && (e.d[W-1] != m[W-1]);
        return e;
    endfunction

    // Result scoreboard: compare on every handshake cycle.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("difference", {24'd0, difference}, {24'd0, e.d});
                chk("borrow_out", {31'd0, borrow_out}, {31'd0, e.b});
`ifdef SERIAL_SUB_OVERFLOW_EN
                chk("overflow", {31'd0, overflow}, {31'd0, e.ov});
`endif
            end
        end
    end

    // Wait (bounded) for in_ready, then offer operands for one edge (T0).
    task automatic start_op(input logic [W-1:0] m, input logic [W-1:0] s, input logic b,
                            input bit push);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            chk("timeout_in_ready", 32'd0, 32'd1);
            return;
        end
        in_valid   = 1'b1;
        minuend    = m;
        subtrahend = s;
        borrow_in  = b;
        if (push) exp_q.push_back(model(m, s, b));
        @(posedge clk); #1;
        in_valid   = 1'b0;
    endtask

    // Full operation with out_ready held high; returns once back in IDLE.
    task automatic do_op(input logic [W-1:0] m, input logic [W-1:0] s, input logic b);
        int n;
        start_op(m, s, b, 1'b1);
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("timeout_done", 32'd0, 32'd1);
    endtask

    initial begin
        int n;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        minuend    = '0;
        subtrahend = '0;
        borrow_in  = 1'b0;
        out_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",   {31'd0, in_ready},   32'd1);
        chk("rst_out_valid",  {31'd0, out_valid},  32'd0);
        chk("rst_busy",       {31'd0, busy},       32'd0);
        chk("rst_difference", {24'd0, difference}, 32'd0);
        chk("rst_borrow_out", {31'd0, borrow_out}, 32'd0);
`ifdef SERIAL_SUB_OVERFLOW_EN
        chk("rst_overflow",   {31'd0, overflow},   32'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 0x5A - 0x23 with latency checks around T8.
        start_op(8'h5A, 8'h23, 1'b0, 1'b1);   // now just after T0
        chk("t0_busy", {31'd0, busy}, 32'd1);
        repeat (7) @(posedge clk);
        #1;
        chk("t7_out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        chk("t8_out_valid", {31'd0, out_valid}, 32'd1);
        chk("t8_in_ready",  {31'd0, in_ready},  32'd0);
        @(posedge clk); #1;
        chk("post_done_in_ready",  {31'd0, in_ready},  32'd1);
        chk("post_done_out_valid", {31'd0, out_valid}, 32'd0);
        chk("post_done_busy",      {31'd0, busy},      32'd0);

        do_op(8'h00, 8'h01, 1'b0);
        do_op(8'h10, 8'h10, 1'b1);

        // Backpressure with a rejected in_valid pulse while in DONE.
        out_ready = 1'b0;
        start_op(8'hC8, 8'h64, 1'b0, 1'b1);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_reach_done", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                in_valid   = 1'b1;
                minuend    = 8'h11;
                subtrahend = 8'h22;
            end else begin
                in_valid   = 1'b0;
            end
            @(posedge clk); #1;
            chk("bp_out_valid",  {31'd0, out_valid},  32'd1);
            chk("bp_difference", {24'd0, difference}, 32'h64);
            chk("bp_borrow_out", {31'd0, borrow_out}, 32'd0);
            chk("bp_in_ready",   {31'd0, in_ready},   32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_release_in_ready",  {31'd0, in_ready},  32'd1);
        chk("bp_release_busy",      {31'd0, busy},      32'd0);

        // Reset on edge T3 of 0xFF - 0x01.
        start_op(8'hFF, 8'h01, 1'b0, 1'b0);   // just after T0
        repeat (2) @(posedge clk);
        #1;                                   // just after T2
        rst_n = 1'b0;
        @(posedge clk); #1;                   // T3 with reset
        rst_n = 1'b1;
        chk("mid_rst_out_valid",  {31'd0, out_valid},  32'd0);
        chk("mid_rst_busy",       {31'd0, busy},       32'd0);
        chk("mid_rst_difference", {24'd0, difference}, 32'd0);
        chk("mid_rst_in_ready",   {31'd0, in_ready},   32'd1);
        chk("mid_rst_borrow_out", {31'd0, borrow_out}, 32'd0);
        do_op(8'h05, 8'h03, 1'b0);

`ifdef SERIAL_SUB_OVERFLOW_EN
        do_op(8'h80, 8'h01, 1'b0);
        do_op(8'h7F, 8'h01, 1'b0);
`endif

        // Corner and random operands.
        do_op(8'h00, 8'h00, 1'b1);
        do_op(8'hFF, 8'hFF, 1'b0);
        do_op(8'hFF, 8'h00, 1'b1);
        for (int i = 0; i < 16; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom));
        end

        repeat (2) @(posedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor built around a single full-subtractor cell and a registered borrow. It computes `minuend - subtrahend - borrow_in` LSB-first, one bit per clock, for area-constrained datapaths. Its output is the same unsigned/two's-complement word that a ripple adder chain produces. It sits beside the adder cells in the arithmetic library and uses valid/ready handshakes on both operand intake and result delivery.

## Interface
- `WIDTH`, default 8, operand and result width in bits (legal range ≥ 1)
- `clk`  input  1  rising-edge clock
- `rst_n`  input  1  reset; synchronous, active-low
- `in_valid`  input  1  operands and `borrow_in` are valid
- `in_ready`  output  1  block can accept operands (high only in IDLE)
- `minuend`  input  WIDTH  left operand
- `subtrahend`  input  WIDTH  right operand
- `borrow_in`  input  1  incoming borrow, subtracted at bit 0
- `out_valid`  output  1  result valid
- `out_ready`  input  1  consumer accepts result
- `difference`  output  WIDTH  result, modulo 2^WIDTH
- `borrow_out`  output  1  final borrow (1 ⇔ unsigned `minuend < subtrahend + borrow_in`)
- `busy`  output  1  high in SHIFT or DONE
- `overflow`  output  1  signed overflow flag (present only with `SERIAL_SUB_OVERFLOW_EN`)

## Operation
- FSM has three states: IDLE, SHIFT and DONE.
- **IDLE**
  - `in_ready`=1.
  - On an edge with `in_valid`=1: latch both operands into shift registers and load the borrow register with `borrow_in`.
  - Clear the bit counter and go to SHIFT.
- **SHIFT**, one bit per edge:
  - Take a = minuend[0] and b = subtrahend[0].
  - d = a ^ b ^ brw.
  - brw' = (~a & b) | (~(a ^ b) & brw).
  - Shift d into the result MSB. Shift the operands right. Increment the counter.
  - After WIDTH edges in SHIFT, go to DONE.
- **DONE**
  - `out_valid`=1, and `difference`/`borrow_out` hold the final values.
  - Stay in DONE until `out_ready`=1, then go to IDLE on that edge.
- `in_valid` is ignored outside IDLE, so operands offered there are not accepted.
- `difference` and `borrow_out` change only in SHIFT and stay stable through DONE.
- The result register is not cleared on return to IDLE.
- Counter width is $clog2(WIDTH+1).
- For WIDTH=1, SHIFT lasts exactly one edge.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `busy`=0, `difference`=0, `borrow_out`=0, `overflow`=0.
- `rst_n` low at any edge, including mid-SHIFT or in DONE, discards the operation. All outputs return to their reset values on that edge.
- Accept edge = T0. SHIFT occupies edges T1..TWIDTH.
- `out_valid` rises after edge TWIDTH, giving latency WIDTH+1 edges from acceptance.
- Throughput is one operation per WIDTH+2 cycles with `out_ready` held high: DONE→IDLE costs one edge, and `in_ready` is low in DONE.
- `out_valid`=1 with `out_ready`=0: all outputs hold indefinitely.

## Configuration
- `SERIAL_SUB_OVERFLOW_EN` defined:
  - The `overflow` port exists.
  - It is registered in DONE as (m[MSB] ≠ s[MSB]) & (difference[MSB] ≠ m[MSB]), using the operand MSBs latched at acceptance. `borrow_in` is ignored in this formula.
  - It is held through DONE and cleared on reset.
- Undefined: the `overflow` port and its logic are absent, and all other behaviour is identical.

## Test plan
- WIDTH=8, accept 0x5A − 0x23, `borrow_in`=0, `out_ready`=1 → `out_valid` high after edge T8, `difference`=0x37, `borrow_out`=0, `in_ready` back to 1 one edge after DONE.
- 0x00 − 0x01, `borrow_in`=0 → `difference`=0xFF, `borrow_out`=1.
- 0x10 − 0x10, `borrow_in`=1 → `difference`=0xFF, `borrow_out`=1.
- Backpressure: 0xC8 − 0x64 with `out_ready`=0 for 5 cycles after DONE, and `in_valid` pulsed meanwhile:
  - `out_valid` held, `difference`=0x64 stable, `borrow_out`=0.
  - `in_ready`=0 and the pulsed operands are not accepted.
  - Completes on the first `out_ready`=1 edge.
- Reset mid-operation: drop `rst_n` on edge T3 of 0xFF − 0x01 → next cycle `out_valid`=0, `busy`=0, `difference`=0, `in_ready`=1. A subsequent 0x05 − 0x03 yields 0x02, `borrow_out`=0.
- With `SERIAL_SUB_OVERFLOW_EN`:
  - 0x80 − 0x01 → `difference`=0x7F, `overflow`=1.
  - 0x7F − 0x01 → 0x7E, `overflow`=0.
